// File: rtl/cpu_run_ctrl_if.sv
// Bundle between the run controller and its environment: CPU commit
// stream and run control in, CPU reset, status, watch shadows and trace out.
interface cpu_run_ctrl_if #(
   parameter int XLEN   = 32,
   parameter int NWATCH = 4
);
   logic                   start;
   logic                   rf_we;
   logic [4:0]             rf_waddr;
   logic [XLEN-1:0]        rf_wdata;
   logic [XLEN-1:0]        pc;
   logic [NWATCH*5-1:0]    watch_addr;
   logic                   cpu_reset;
   logic                   running;
   logic                   done;
   logic [1:0]             done_cause;
   logic [31:0]            cycle_count;
   logic [NWATCH*XLEN-1:0] watch_val;
   logic [NWATCH-1:0]      watch_hit;
   logic                   trace_valid;
   logic [4:0]             trace_addr;
   logic [XLEN-1:0]        trace_data;

   modport master (
      output start, rf_we, rf_waddr, rf_wdata, pc, watch_addr,
      input  cpu_reset, running, done, done_cause, cycle_count,
             watch_val, watch_hit, trace_valid, trace_addr, trace_data
   );

   modport slave (
      input  start, rf_we, rf_waddr, rf_wdata, pc, watch_addr,
      output cpu_reset, running, done, done_cause, cycle_count,
             watch_val, watch_hit, trace_valid, trace_addr, trace_data
   );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run controller: holds the CPU in reset, runs it until halt (stable PC) or
// cycle budget, shadows watched register writes and echoes them as a trace.
module cpu_run_ctrl #(
   parameter int          XLEN         = 32,
   parameter int          RESET_CYCLES = 10,
   parameter int unsigned MAX_CYCLES   = 500,
   parameter int          NWATCH       = 4,
   parameter int          HALT_WINDOW  = 8
) (
   input logic          clk,
   input logic          reset,
   cpu_run_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, HOLD, RUN, DONE} state_t;

   localparam int              HCW        = $clog2(RESET_CYCLES + 1);
   localparam int              SCW        = $clog2(HALT_WINDOW + 1);
   localparam logic [HCW-1:0]  HOLD_LAST  = HCW'(RESET_CYCLES - 1);
   localparam logic [SCW-1:0]  HALT_LAST  = SCW'(HALT_WINDOW - 1);
   localparam logic [31:0]     LAST_CYCLE = 32'(MAX_CYCLES - 1);

   state_t                        state, state_n;
   logic [HCW-1:0]                hold_cnt;
   logic [SCW-1:0]                stable_cnt, stable_n;
   logic [XLEN-1:0]               pc_prev;
   logic                          pc_cmp_ok;
   logic                          halt, timeout, enter_hold;
   logic [NWATCH-1:0][4:0]        wa;
   logic [NWATCH-1:0]             match;
   logic [NWATCH-1:0][XLEN-1:0]   wval;
   logic [NWATCH-1:0]             whit;

   assign wa            = bus.watch_addr;
   assign bus.watch_val = wval;
   assign bus.watch_hit = whit;

   // pc_cmp_ok is low on the first RUN cycle so it always counts as a change
   always_comb begin
      match    = '0;
      for (int i = 0; i < NWATCH; i++)
         match[i] = bus.rf_we && (bus.rf_waddr != 5'd0) && (wa[i] == bus.rf_waddr);
      stable_n = '0;
      if (state == RUN && pc_cmp_ok && bus.pc == pc_prev)
         stable_n = stable_cnt + 1'b1;
      halt     = (state == RUN) && (stable_n == HALT_LAST);
      timeout  = (state == RUN) && (bus.cycle_count == LAST_CYCLE);
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (bus.start) state_n = HOLD;
         HOLD:    if (hold_cnt == HOLD_LAST) state_n = RUN;
         RUN:     if (halt || timeout) state_n = DONE;
         DONE:    if (bus.start) state_n = HOLD;
         default: state_n = IDLE;
      endcase
      enter_hold = (state_n == HOLD) && (state != HOLD);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= IDLE;
         hold_cnt        <= '0;
         stable_cnt      <= '0;
         pc_prev         <= '0;
         pc_cmp_ok       <= 1'b0;
         bus.cpu_reset   <= 1'b1;
         bus.running     <= 1'b0;
         bus.done        <= 1'b0;
         bus.done_cause  <= 2'b00;
         bus.cycle_count <= '0;
         bus.trace_valid <= 1'b0;
         bus.trace_addr  <= '0;
         bus.trace_data  <= '0;
         wval            <= '0;
         whit            <= '0;
      end else begin
         state         <= state_n;
         pc_prev       <= bus.pc;
         pc_cmp_ok     <= (state == RUN);
         hold_cnt      <= (state == HOLD) ? hold_cnt + 1'b1 : '0;
         bus.cpu_reset <= (state_n != RUN);
         bus.running   <= (state_n == RUN);
         bus.done      <= (state_n == DONE);

         if (enter_hold) begin
            bus.cycle_count <= '0;
            bus.done_cause  <= 2'b00;
            stable_cnt      <= '0;
            wval            <= '0;
            whit            <= '0;
         end else if (state == RUN) begin
            stable_cnt <= stable_n;
            if (halt)         bus.done_cause  <= 2'b10;
            else if (timeout) bus.done_cause  <= 2'b01;
            else              bus.cycle_count <= bus.cycle_count + 32'd1;
            for (int i = 0; i < NWATCH; i++) begin
               if (match[i]) begin
                  wval[i] <= bus.rf_wdata;
                  whit[i] <= 1'b1;
               end
            end
         end

         // A write on the final RUN cycle updates the shadow but is not traced,
         // so trace_valid never appears outside RUN.
         bus.trace_valid <= 1'b0;
         if (state == RUN && state_n == RUN && |match) begin
            bus.trace_valid <= 1'b1;
            bus.trace_addr  <= bus.rf_waddr;
            bus.trace_data  <= bus.rf_wdata;
         end
      end
   end
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Randomized bench for cpu_run_ctrl against a run-level reference model
// (PC history window for halt, per-slot shadow array for watches).
module tb_cpu_run_ctrl;
   localparam int XLEN = 32, NW = 4, RC = 10, MC = 500, HW = 8, MC2 = 16;

   logic clk, reset;

   cpu_run_ctrl_if #(.XLEN(XLEN), .NWATCH(NW)) b1 ();
   cpu_run_ctrl_if #(.XLEN(XLEN), .NWATCH(NW)) b2 ();

   cpu_run_ctrl #(.XLEN(XLEN), .RESET_CYCLES(RC), .MAX_CYCLES(MC), .NWATCH(NW),
                  .HALT_WINDOW(HW)) dut (.clk(clk), .reset(reset), .bus(b1));
   cpu_run_ctrl #(.XLEN(XLEN), .RESET_CYCLES(RC), .MAX_CYCLES(MC2), .NWATCH(NW),
                  .HALT_WINDOW(HW)) dut2 (.clk(clk), .reset(reset), .bus(b2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0, bad = 0;
   logic [XLEN-1:0]    m_val [NW];
   logic [NW-1:0]      m_hit;
   logic               m_tv;
   logic [4:0]         m_ta;
   logic [XLEN-1:0]    m_td;
   logic [NW-1:0][4:0] wa_cur;
   int                 dw_k [$];
   logic [4:0]         dw_a [$];
   logic [XLEN-1:0]    dw_d [$];
   int                 tv_seen, end_k;
   logic [1:0]         end_cause;

   // Drives one run from start to DONE (or to an aborting reset), checking every cycle.
   task automatic run_scenario(input int stable_from, input int wr_pct,
                               input int abort_at, input int wa_change_at);
      logic [XLEN-1:0] pch [$];
      logic [XLEN-1:0] pa, pb, pcv, d;
      logic [4:0] a;
      logic we, watched, halt, tmo;
      int k;
      bit fin;
      pa = 32'h1000 + 32'($urandom_range(0, 1023) << 3);
      pb = pa + 32'd4;
      tv_seen = 0;
      b1.watch_addr = wa_cur;
      b1.start = 1'b1;
      @(negedge clk);
      b1.start = 1'b0;
      for (int i = 0; i < NW; i++) m_val[i] = '0;
      m_hit = '0;
      m_tv  = 1'b0;
      for (int h = 0; h < RC; h++) begin
         total++;
         if ({b1.cpu_reset, b1.running, b1.done, b1.trace_valid} !== 4'b1000) begin
            bad++;
            $display("FAIL hold_status h=%0d got=%b want=1000", h,
                     {b1.cpu_reset, b1.running, b1.done, b1.trace_valid});
         end
         total++;
         if ({b1.done_cause, b1.cycle_count, b1.watch_hit} !== '0) begin
            bad++;
            $display("FAIL hold_cleared h=%0d cause=%b count=%0d hit=%b want all 0", h,
                     b1.done_cause, b1.cycle_count, b1.watch_hit);
         end
         b1.start    = (h == 3);
         b1.pc       = $urandom;
         b1.rf_we    = 1'($urandom_range(0, 1));
         b1.rf_waddr = wa_cur[$urandom_range(0, NW - 1)];
         b1.rf_wdata = $urandom;
         @(negedge clk);
      end
      b1.start = 1'b0;

      k   = 0;
      fin = 0;
      while (!fin) begin
         total++;
         if ({b1.cpu_reset, b1.running, b1.done} !== 3'b010) begin
            bad++;
            $display("FAIL run_status k=%0d got=%b want=010", k,
                     {b1.cpu_reset, b1.running, b1.done});
         end
         total++;
         if (b1.cycle_count !== 32'(k)) begin
            bad++;
            $display("FAIL run_cycle_count got=%0d want=%0d", b1.cycle_count, k);
         end
         total++;
         if (b1.watch_hit !== m_hit) begin
            bad++;
            $display("FAIL run_watch_hit k=%0d got=%b want=%b", k, b1.watch_hit, m_hit);
         end
         for (int i = 0; i < NW; i++) begin
            total++;
            if (b1.watch_val[i*XLEN +: XLEN] !== m_val[i]) begin
               bad++;
               $display("FAIL run_watch_val[%0d] k=%0d got=%h want=%h", i, k,
                        b1.watch_val[i*XLEN +: XLEN], m_val[i]);
            end
         end
         total++;
         if (b1.trace_valid !== m_tv ||
             (m_tv && {b1.trace_addr, b1.trace_data} !== {m_ta, m_td})) begin
            bad++;
            $display("FAIL run_trace k=%0d got v=%b a=%0d d=%h want v=%b a=%0d d=%h", k,
                     b1.trace_valid, b1.trace_addr, b1.trace_data, m_tv, m_ta, m_td);
         end
         if (b1.trace_valid === 1'b1) tv_seen++;

         if (k == abort_at) begin
            #2 reset = 1'b1;
            #1;
            total++;
            if (b1.cpu_reset !== 1'b1 ||
                {b1.running, b1.done, b1.done_cause, b1.cycle_count, b1.watch_val,
                 b1.watch_hit, b1.trace_valid, b1.trace_addr, b1.trace_data} !== '0) begin
               bad++;
               $display("FAIL async_reset rst=%b run=%b done=%b cause=%b count=%0d hit=%b tv=%b want 1/0/0/0/0/0/0",
                        b1.cpu_reset, b1.running, b1.done, b1.done_cause, b1.cycle_count,
                        b1.watch_hit, b1.trace_valid);
            end
            @(negedge clk);
            reset    = 1'b0;
            b1.rf_we = 1'b0;
            for (int j = 0; j < 5; j++) begin
               @(negedge clk);
               total++;
               if ({b1.cpu_reset, b1.running, b1.done} !== 3'b100) begin
                  bad++;
                  $display("FAIL abort_idle j=%0d got=%b want=100", j,
                           {b1.cpu_reset, b1.running, b1.done});
               end
            end
            end_k     = k;
            end_cause = 2'b00;
            return;
         end

         if (k == wa_change_at) begin
            for (int i = 0; i < NW; i++) wa_cur[i] = 5'($urandom_range(0, 7));
            b1.watch_addr = wa_cur;
         end
         pcv = (stable_from >= 0 && k >= stable_from) ? 32'h40 : (k[0] ? pb : pa);
         pch.push_back(pcv);
         b1.pc = pcv;
         we = 1'b0;
         a  = 5'd0;
         d  = $urandom;
         if (dw_k.size() > 0 && dw_k[0] == k) begin
            we = 1'b1;
            a  = dw_a.pop_front();
            d  = dw_d.pop_front();
            void'(dw_k.pop_front());
         end else if ($urandom_range(0, 99) < wr_pct) begin
            we = 1'b1;
            a  = ($urandom_range(0, 1) != 0) ? wa_cur[$urandom_range(0, NW - 1)]
                                             : 5'($urandom_range(0, 31));
         end
         b1.rf_we    = we;
         b1.rf_waddr = a;
         b1.rf_wdata = d;
         b1.start    = (k == 3);

         // Halt: the last HALT_WINDOW RUN-cycle PCs are all identical.
         halt = 1'b0;
         if (pch.size() >= HW) begin
            halt = 1'b1;
            for (int j = 1; j < HW; j++)
               if (pch[pch.size() - 1 - j] !== pcv) halt = 1'b0;
         end
         tmo       = (k == MC - 1);
         fin       = halt || tmo;
         end_cause = halt ? 2'b10 : 2'b01;
         watched   = 1'b0;
         if (we && a != 5'd0) begin
            for (int i = 0; i < NW; i++) begin
               if (wa_cur[i] == a) begin
                  m_val[i] = d;
                  m_hit[i] = 1'b1;
                  watched  = 1'b1;
               end
            end
         end
         m_tv = watched && !fin;
         if (m_tv) begin
            m_ta = a;
            m_td = d;
         end
         @(negedge clk);
         if (!fin) k++;
      end
      end_k    = k;
      b1.start = 1'b0;

      for (int j = 0; j < 4; j++) begin
         total++;
         if ({b1.cpu_reset, b1.running, b1.done, b1.trace_valid} !== 4'b1010) begin
            bad++;
            $display("FAIL done_status j=%0d got=%b want=1010", j,
                     {b1.cpu_reset, b1.running, b1.done, b1.trace_valid});
         end
         total++;
         if (b1.done_cause !== end_cause || b1.cycle_count !== 32'(end_k)) begin
            bad++;
            $display("FAIL done_frozen j=%0d cause=%b count=%0d want cause=%b count=%0d", j,
                     b1.done_cause, b1.cycle_count, end_cause, end_k);
         end
         total++;
         if (b1.watch_hit !== m_hit) begin
            bad++;
            $display("FAIL done_watch_hit got=%b want=%b", b1.watch_hit, m_hit);
         end
         for (int i = 0; i < NW; i++) begin
            total++;
            if (b1.watch_val[i*XLEN +: XLEN] !== m_val[i]) begin
               bad++;
               $display("FAIL done_watch_val[%0d] got=%h want=%h", i,
                        b1.watch_val[i*XLEN +: XLEN], m_val[i]);
            end
         end
         b1.rf_we    = 1'b1;
         b1.rf_waddr = wa_cur[j % NW];
         b1.rf_wdata = $urandom;
         b1.pc       = $urandom;
         @(negedge clk);
      end
      b1.rf_we = 1'b0;
   endtask

   task automatic rand_watch();
      for (int i = 0; i < NW; i++) wa_cur[i] = 5'($urandom_range(0, 7));
   endtask

   task automatic test_reset();
      reset = 1'b1;
      {b1.start, b1.rf_we, b1.rf_waddr, b1.rf_wdata, b1.pc, b1.watch_addr} = '0;
      {b2.start, b2.rf_we, b2.rf_waddr, b2.rf_wdata, b2.pc, b2.watch_addr} = '0;
      repeat (3) @(negedge clk);
      total++;
      if ({b1.cpu_reset, b1.running, b1.done} !== 3'b100) begin
         bad++;
         $display("FAIL reset_status got=%b want=100", {b1.cpu_reset, b1.running, b1.done});
      end
      total++;
      if ({b1.done_cause, b1.cycle_count, b1.watch_val, b1.watch_hit} !== '0) begin
         bad++;
         $display("FAIL reset_state cause=%b count=%0d hit=%b want zeros",
                  b1.done_cause, b1.cycle_count, b1.watch_hit);
      end
      total++;
      if ({b1.trace_valid, b1.trace_addr, b1.trace_data} !== '0) begin
         bad++;
         $display("FAIL reset_trace v=%b a=%0d d=%h want 0", b1.trace_valid,
                  b1.trace_addr, b1.trace_data);
      end
      total++;
      if ({b2.cpu_reset, b2.running, b2.done, b2.done_cause} !== 5'b10000) begin
         bad++;
         $display("FAIL reset_dut2 got=%b want=10000",
                  {b2.cpu_reset, b2.running, b2.done, b2.done_cause});
      end
      reset = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if ({b1.cpu_reset, b1.running, b1.done} !== 3'b100) begin
         bad++;
         $display("FAIL idle_no_start got=%b want=100", {b1.cpu_reset, b1.running, b1.done});
      end
   endtask

   task automatic test_timeout();
      for (int i = 0; i < NW; i++) wa_cur[i] = 5'($urandom_range(1, 7));
      run_scenario(-1, 30, -1, 250);
      total++;
      if (b1.done_cause !== 2'b01 || b1.cycle_count !== 32'd499) begin
         bad++;
         $display("FAIL timeout_end cause=%b count=%0d want cause=01 count=499",
                  b1.done_cause, b1.cycle_count);
      end
   endtask

   task automatic test_watch();
      wa_cur = {5'd24, 5'd6, 5'd2, 5'd1};
      dw_k = '{5, 9};
      dw_a = '{5'd2, 5'd24};
      dw_d = '{32'd7, 32'hDEAD};
      run_scenario(30, 0, -1, -1);
      total++;
      if (b1.watch_val[63:32] !== 32'd7 || b1.watch_val[127:96] !== 32'hDEAD ||
          b1.watch_val[31:0] !== 32'd0 || b1.watch_val[95:64] !== 32'd0) begin
         bad++;
         $display("FAIL watch_values got=%h want=0000dead_00000000_00000007_00000000",
                  b1.watch_val);
      end
      total++;
      if (b1.watch_hit !== 4'b1010) begin
         bad++;
         $display("FAIL watch_hit_dir got=%b want=1010", b1.watch_hit);
      end
      total++;
      if (tv_seen != 2) begin
         bad++;
         $display("FAIL watch_trace_pulses got=%0d want=2", tv_seen);
      end
   endtask

   task automatic test_halt();
      rand_watch();
      run_scenario(20, 40, -1, -1);
      total++;
      if (b1.done_cause !== 2'b10 || b1.cycle_count !== 32'd27) begin
         bad++;
         $display("FAIL halt_end cause=%b count=%0d want cause=10 count=27",
                  b1.done_cause, b1.cycle_count);
      end
   endtask

   task automatic test_x0();
      wa_cur = {5'd3, 5'd0, 5'd9, 5'd0};
      dw_k = '{2, 4};
      dw_a = '{5'd0, 5'd0};
      dw_d = '{32'd5, 32'd5};
      run_scenario(10, 0, -1, -1);
      total++;
      if (b1.watch_val !== '0 || b1.watch_hit !== 4'b0000) begin
         bad++;
         $display("FAIL x0_ignored val=%h hit=%b want 0", b1.watch_val, b1.watch_hit);
      end
      total++;
      if (tv_seen != 0) begin
         bad++;
         $display("FAIL x0_trace got=%0d pulses want=0", tv_seen);
      end
   endtask

   task automatic test_random();
      for (int r = 0; r < 4; r++) begin
         rand_watch();
         run_scenario(($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(8, 150)),
                      50, -1, 40);
         total++;
         if (b1.done_cause !== end_cause) begin
            bad++;
            $display("FAIL random_cause r=%0d got=%b want=%b", r, b1.done_cause, end_cause);
         end
      end
   endtask

   task automatic test_reset_midrun();
      rand_watch();
      run_scenario(-1, 40, 100, -1);
      rand_watch();
      run_scenario(12, 40, -1, -1);
      total++;
      if (b1.done_cause !== 2'b10 || b1.cycle_count !== 32'd19) begin
         bad++;
         $display("FAIL rerun_end cause=%b count=%0d want cause=10 count=19",
                  b1.done_cause, b1.cycle_count);
      end
   endtask

   // Small-budget instance: PC goes stable at RUN cycle sf.
   task automatic test_coincide(input int sf);
      int hk, ek;
      logic [1:0] ec;
      hk = sf + HW - 1;
      ek = (hk < MC2 - 1) ? hk : MC2 - 1;
      ec = (hk <= MC2 - 1) ? 2'b10 : 2'b01;
      b2.start = 1'b1;
      @(negedge clk);
      b2.start = 1'b0;
      repeat (RC) begin
         b2.pc = $urandom;
         @(negedge clk);
      end
      for (int k = 0; k <= ek; k++) begin
         total++;
         if (b2.running !== 1'b1 || b2.cycle_count !== 32'(k)) begin
            bad++;
            $display("FAIL coincide_run sf=%0d k=%0d running=%b count=%0d", sf, k,
                     b2.running, b2.cycle_count);
         end
         b2.pc = (k < sf) ? 32'(32'h200 + k * 4) : 32'h40;
         @(negedge clk);
      end
      total++;
      if (b2.done !== 1'b1 || b2.running !== 1'b0) begin
         bad++;
         $display("FAIL coincide_done sf=%0d done=%b running=%b want 1/0", sf, b2.done, b2.running);
      end
      total++;
      if (b2.done_cause !== ec || b2.cycle_count !== 32'(ek)) begin
         bad++;
         $display("FAIL coincide_cause sf=%0d cause=%b count=%0d want cause=%b count=%0d", sf,
                  b2.done_cause, b2.cycle_count, ec, ek);
      end
   endtask

   initial begin
      test_reset();
      test_timeout();
      test_watch();
      test_halt();
      test_x0();
      test_random();
      test_reset_midrun();
      test_coincide(8);
      test_coincide(9);
      test_coincide(3);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1);
   end
endmodule
